// File: rtl/mfp_uart_transmitter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : mfp_uart_transmitter
//  Brief    : 8N1 serial transmitter fed by a byte FIFO over a valid/ready port.
//  Revision : 1.0  initial release
// ============================================================================
module mfp_uart_transmitter #(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int BAUD            = 115_200,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [7:0]                 byte_data,
  input  logic                       byte_valid,
  output logic                       byte_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count
);

  localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int DEPTH        = 1 << FIFO_DEPTH_LOG2;
  localparam int PTR_W        = FIFO_DEPTH_LOG2;

  localparam logic [CNT_W-1:0]   BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]     FULL_COUNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             state_q,   state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]         idx_q,     idx_d;
  logic [7:0]         shift_q,   shift_d;
  logic               tx_q,      tx_d;
  logic [PTR_W-1:0]   wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,  rd_ptr_d;
  logic [PTR_W:0]     count_q,   count_d;
  logic [7:0]         mem_q [DEPTH];

  logic push;
  logic pop;
  logic bit_end;

  // Ready depends only on the registered count, so a full FIFO refuses a
  // write even when the transmitter pops in the same cycle.
  assign byte_ready = (count_q != FULL_COUNT);
  assign push       = byte_valid && byte_ready;
  assign bit_end    = (bit_cnt_q == BIT_LAST);

  // Transmit sequencer: pop decisions are made here, FIFO bookkeeping below.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_d      = 1'b1;
        bit_cnt_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          idx_d     = 3'd0;
          tx_d      = shift_q[0];
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          bit_cnt_d = '0;
          // Chain straight into the next start bit to keep frames gapless.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      default: begin
        tx_d      = 1'b1;
        bit_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: entries are only read below the valid count.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= byte_data;
    end
  end

  assign tx         = tx_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_mfp_uart_transmitter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mfp_uart_transmitter
//  Brief    : Self-checking bench; a line monitor decodes tx into bytes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mfp_uart_transmitter;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int FRAME    = 10 * CPB;
  localparam int LOG2     = 4;
  localparam int DEPTH    = 1 << LOG2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [7:0]      byte_data = 8'h00;
  logic            byte_valid = 1'b0;
  logic            byte_ready;
  logic            tx;
  logic            busy;
  logic [LOG2:0]   fifo_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] rx_bytes[$];
  int         rx_starts[$];
  logic [7:0] exp_q[$];

  mfp_uart_transmitter #(
    .CLK_FREQ        (CLK_FREQ),
    .BAUD            (BAUD),
    .FIFO_DEPTH_LOG2 (LOG2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Line decoder: samples mid-bit, drops frames cut short by reset.
  initial begin : monitor
    logic [9:0] bits;
    bit         aborted;
    int         t0;
    forever begin
      @(negedge clock);
      if (!reset && tx === 1'b0) begin
        t0      = cyc;
        aborted = 1'b0;
        bits    = '0;
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge clock);
          if (reset) aborted = 1'b1;
          if (!aborted && (i % CPB) == CPB / 2) bits[i / CPB] = tx;
        end
        if (!aborted) begin
          check_eq("start_bit", 32'(bits[0]), 32'd0);
          check_eq("stop_bit", 32'(bits[9]), 32'd1);
          rx_bytes.push_back(bits[8:1]);
          rx_starts.push_back(t0);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] d, output bit acc);
    byte_data  = d;
    byte_valid = 1'b1;
    acc        = byte_ready;
    step();
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      step();
      n++;
    end
    check_eq("idle_reached", 32'(busy), 32'd0);
    repeat (3) step();
  endtask

  task automatic clear_logs();
    rx_bytes.delete();
    rx_starts.delete();
    exp_q.delete();
  endtask

  task automatic compare_logs(input string tag);
    check_eq({tag, "_nframes"}, rx_bytes.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_bytes.size(); i++) begin
      check_eq({tag, "_byte"}, 32'(rx_bytes[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin : main
    bit         acc;
    logic [7:0] d;
    int         e;
    int         tries;
    logic       exp_bit;

    repeat (3) step();
    reset = 1'b0;
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    check_eq("rst_ready", 32'(byte_ready), 32'd1);
    repeat (5) step();

    // Test 1: single 0x55 frame, cycle-exact waveform.
    clear_logs();
    d = 8'h55;
    send(d, acc);
    check_eq("t1_acc", 32'(acc), 32'd1);
    check_eq("t1_count", 32'(fifo_count), 32'd1);
    step();
    for (int j = 0; j < FRAME; j++) begin
      if (j < CPB)            exp_bit = 1'b0;
      else if (j >= 9 * CPB)  exp_bit = 1'b1;
      else                    exp_bit = d[j / CPB - 1];
      check_eq("t1_tx", 32'(tx), 32'(exp_bit));
      if (j == FRAME - 1) check_eq("t1_busy_last", 32'(busy), 32'd1);
      step();
    end
    check_eq("t1_busy_done", 32'(busy), 32'd0);
    check_eq("t1_tx_idle", 32'(tx), 32'd1);
    exp_q.push_back(8'h55);
    compare_logs("t1");

    // Test 2: two bytes back-to-back, no idle gap.
    clear_logs();
    send(8'hA5, acc);
    check_eq("t2_acc0", 32'(acc), 32'd1);
    send(8'h3C, acc);
    check_eq("t2_acc1", 32'(acc), 32'd1);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    wait_idle(4 * FRAME);
    compare_logs("t2");
    if (rx_starts.size() == 2) check_eq("t2_gap", rx_starts[1] - rx_starts[0], FRAME);

    // Test 3: fill the FIFO behind an in-flight frame; the 17th byte is dropped.
    clear_logs();
    send(8'h11, acc);
    exp_q.push_back(8'h11);
    repeat (20) step();
    check_eq("t3_inflight_count", 32'(fifo_count), 32'd0);
    check_eq("t3_inflight_busy", 32'(busy), 32'd1);
    for (int k = 0; k <= DEPTH; k++) begin
      d = 8'($urandom);
      send(d, acc);
      check_eq("t3_acc", 32'(acc), (k < DEPTH) ? 32'd1 : 32'd0);
      if (k < DEPTH) exp_q.push_back(d);
      if (k == DEPTH - 1) begin
        check_eq("t3_full_count", 32'(fifo_count), 32'(DEPTH));
        check_eq("t3_full_ready", 32'(byte_ready), 32'd0);
      end
    end
    wait_idle((DEPTH + 3) * FRAME);
    compare_logs("t3");
    for (int i = 1; i < rx_starts.size(); i++) begin
      check_eq("t3_gap", rx_starts[i] - rx_starts[i - 1], FRAME);
    end

    // Test 4: reset during data bit 3 of 0xFF with 4 bytes queued.
    clear_logs();
    send(8'hFF, acc);
    e = cyc;
    for (int k = 0; k < 4; k++) send(8'($urandom), acc);
    check_eq("t4_queued", 32'(fifo_count), 32'd4);
    while (cyc < e + 1 + 4 * CPB + CPB / 2) step();
    check_eq("t4_bit3", 32'(tx), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("t4_tx", 32'(tx), 32'd1);
    check_eq("t4_count", 32'(fifo_count), 32'd0);
    check_eq("t4_busy", 32'(busy), 32'd0);
    check_eq("t4_ready", 32'(byte_ready), 32'd1);
    repeat (3 * FRAME) step();
    check_eq("t4_no_frames", rx_bytes.size(), 0);
    check_eq("t4_still_idle", 32'(busy), 32'd0);

    // Test 6: write coincident with the pop of the last entry.
    clear_logs();
    send(8'h81, acc);
    e = cyc;
    send(8'h42, acc);
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h42);
    while (cyc < e + FRAME) step();
    check_eq("t6_before", 32'(fifo_count), 32'd1);
    send(8'hE7, acc);
    exp_q.push_back(8'hE7);
    check_eq("t6_acc", 32'(acc), 32'd1);
    check_eq("t6_after", 32'(fifo_count), 32'd1);
    wait_idle(4 * FRAME);
    compare_logs("t6");
    for (int i = 1; i < rx_starts.size(); i++) begin
      check_eq("t6_gap", rx_starts[i] - rx_starts[i - 1], FRAME);
    end

    // Test 5: 256 bytes with random valid gaps, no loss or reordering.
    clear_logs();
    for (int v = 0; v < 256; v++) begin
      repeat ($urandom_range(0, 3)) step();
      tries = 0;
      do begin
        send(8'(v), acc);
        tries++;
      end while (!acc && tries < 4 * FRAME);
      if (!acc) check_eq("t5_accept_timeout", 32'(acc), 32'd1);
      exp_q.push_back(8'(v));
    end
    wait_idle((DEPTH + 3) * FRAME);
    compare_logs("t5");
    for (int i = 1; i < rx_starts.size(); i++) begin
      check_eq("t5_gap_min", 32'(rx_starts[i] - rx_starts[i - 1] >= FRAME), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
